// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for the multicycle ARM-subset core. Decodes the registered
// instruction word, steps each instruction through a Moore state machine,
// evaluates the condition field against an internal NZCV flags register and
// drives every enable / mux select of the datapath and memory.
//
// Build option:
//   CTRL_MUL_EN  defined   -> MUL (op 00, I=0, Instr[7:4]=1001) is executed,
//                             opMul=1 and ALUControl=100 for it.
//                undefined -> opMul tied 0, MUL encodings are unsupported.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   Instr[31:0]    instruction register contents
//   ALUFlags[3:0]  {N,Z,C,V} from the ALU, captured only at EXECUTE->ALUWB
//   PCWrite        PC enable
//   MemWrite       memory write enable
//   RegWrite       register file write enable
//   IRWrite        instruction register enable
//   AdrSrc         memory address: 0 = PC, 1 = Result
//   RegSrc[1:0]    [0] R15 -> RA1, [1] Rd -> RA2
//   ALUSrcA        0 = A, 1 = PC
//   ALUSrcB[1:0]   0 = WriteData, 1 = ExtImm, 2 = constant 4
//   ResultSrc[1:0] 0 = ALUOut, 1 = Data, 2 = ALUResult
//   ImmSrc[1:0]    Instr[27:26]
//   ALUControl[2:0] 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL
//   opMul          current instruction is MUL (register field remap)
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic        opMul
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic [1:0] op;
  logic [3:0] cmd;
  logic       mul_pattern;
  logic       is_mul;
  logic       dp_ok;
  logic       is_cmp;
  logic       nz_only;
  logic [2:0] alu_op;
  logic       rd_is_pc;
  logic       unused_instr;

  assign op          = Instr[27:26];
  assign cmd         = Instr[24:21];
  assign rd_is_pc    = (Instr[15:12] == 4'hF);
  assign mul_pattern = (op == 2'b00) && !Instr[25] && (Instr[7:4] == 4'b1001);
  // Register/immediate operand fields are consumed by the datapath only.
  assign unused_instr = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

`ifdef CTRL_MUL_EN
  assign is_mul = mul_pattern;
`else
  assign is_mul = 1'b0;
`endif

  always_comb begin
    dp_ok   = 1'b0;
    is_cmp  = 1'b0;
    nz_only = 1'b0;
    alu_op  = ALU_ADD;
    if (is_mul) begin
      dp_ok   = 1'b1;
      nz_only = 1'b1;
      alu_op  = ALU_MUL;
    end else if (!mul_pattern) begin
      // A MUL encoding without MUL support must not alias to AND.
      case (cmd)
        4'b0100: begin dp_ok = 1'b1; alu_op = ALU_ADD; end
        4'b0010: begin dp_ok = 1'b1; alu_op = ALU_SUB; end
        4'b0000: begin dp_ok = 1'b1; alu_op = ALU_AND; nz_only = 1'b1; end
        4'b1100: begin dp_ok = 1'b1; alu_op = ALU_ORR; nz_only = 1'b1; end
        4'b1010: begin dp_ok = 1'b1; alu_op = ALU_SUB; is_cmp = 1'b1; end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Condition evaluation against the registered flags (never ALUFlags)
  // ---------------------------------------------------------------------------
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ex;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (Instr[31:28])
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = !flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = !flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = !flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = !flag_v;
      4'b1000: cond_ex = flag_c && !flag_z;
      4'b1001: cond_ex = !flag_c || flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
      4'b1101: cond_ex = flag_z || (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, flags and latched condition
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign cond_ex_d = (state_q == S_DECODE) ? cond_ex : cond_ex_q;

  // Flags are captured only on the EXECUTE->ALUWB edge; logical ops and MUL
  // keep the previous carry and overflow.
  always_comb begin
    flags_d = flags_q;
    if (((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)) &&
        cond_ex_q && (Instr[20] || is_cmp)) begin
      if (nz_only) flags_d[3:2] = ALUFlags[3:2];
      else         flags_d      = ALUFlags;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    RegSrc     = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        RegSrc    = {(op == 2'b01), (op == 2'b10)};
        case (op)
          2'b00:   state_d = !dp_ok ? S_FETCH : (Instr[25] ? S_EXECUTEI : S_EXECUTER);
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'd1;
        state_d = Instr[20] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'd1;
        RegWrite  = cond_ex_q;
        PCWrite   = cond_ex_q && rd_is_pc;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex_q;
        state_d  = S_FETCH;
      end
      S_EXECUTER: begin
        ALUControl = alu_op;
        state_d    = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB    = 2'd1;
        ALUControl = alu_op;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = cond_ex_q && !is_cmp;
        PCWrite  = cond_ex_q && !is_cmp && rd_is_pc;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'd1;
        ResultSrc = 2'd2;
        PCWrite   = cond_ex_q;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Writes are blocked for as long as reset is held, even mid-cycle.
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

  assign ImmSrc = op;
  assign opMul  = is_mul;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle ARM-subset core. It decodes the registered instruction word, sequences each instruction through a Moore state machine, evaluates condition codes against an internal NZCV flags register, and drives every enable and mux-select consumed by the datapath and memory. It is the consuming end of the datapath's `Instr`/`ALUFlags` outputs and the producing end of its control inputs.

## Interface
- No parameters.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high.
- `Instr` input 32: instruction register contents from the datapath.
- `ALUFlags` input 4: current ALU flags `{N,Z,C,V}`.
- `PCWrite` output 1: PC register enable.
- `MemWrite` output 1: memory write enable.
- `RegWrite` output 1: register file write enable.
- `IRWrite` output 1: instruction register enable.
- `AdrSrc` output 1: selects the memory address source: 0 = PC, 1 = Result.
- `RegSrc` output 2: `[0]` selects R15 for RA1; `[1]` selects Rd for RA2 (store data).
- `ALUSrcA` output 1: 0 = A, 1 = PC.
- `ALUSrcB` output 2: 0 = WriteData, 1 = ExtImm, 2 = constant 4.
- `ResultSrc` output 2: 0 = ALUOut, 1 = Data, 2 = ALUResult.
- `ImmSrc` output 2: equal to `Instr[27:26]`.
- `ALUControl` output 3: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL.
- `opMul` output 1: current instruction is MUL, which remaps the register fields.

## Operation
- **Op decode** (`Instr[27:26]`):
  - 00 is data-processing (DP). Bit 25 selects immediate.
  - 01 is memory. `Instr[20]` = 1 is LDR, 0 is STR.
  - 10 is branch.
  - 11 is unsupported.
- **DP commands** (`Instr[24:21]`): 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP.
  - CMP uses SUB, never writes a register, and always writes flags.
  - Other codes are unsupported.
- **MUL**: Op = 00, `Instr[25]` = 0, `Instr[7:4]` = 1001. Drives `opMul` = 1 and ALUControl = 100.
- **States and per-state outputs**. Unlisted enables are 0; unlisted selects are don't-care, driven 0.
  - FETCH: AdrSrc = 0, IRWrite = 1, ALUSrcA = 1, ALUSrcB = 2, ALU ADD, ResultSrc = 2, PCWrite = 1.
  - DECODE: ALUSrcA = 1, ALUSrcB = 2, ResultSrc = 2. RegSrc is driven from Op.
  - MEMADR: ALUSrcA = 0, ALUSrcB = 1, ADD.
  - MEMREAD: AdrSrc = 1, ResultSrc = 0.
  - MEMWB: ResultSrc = 1, RegWrite = CondExR.
  - MEMWRITE: AdrSrc = 1, ResultSrc = 0, MemWrite = CondExR.
  - EXECUTER: ALUSrcA = 0, ALUSrcB = 0, ALU op from decode.
  - EXECUTEI: ALUSrcA = 0, ALUSrcB = 1, ALU op from decode.
  - ALUWB: ResultSrc = 0, RegWrite = CondExR and not CMP.
  - BRANCH: ALUSrcA = 0, ALUSrcB = 1, ADD, ResultSrc = 2, PCWrite = CondExR.
- **Transitions**:
  - FETCH → DECODE.
  - DECODE → MEMADR (mem), EXECUTER / EXECUTEI (DP by bit 25), BRANCH (10), FETCH (unsupported).
  - MEMADR → MEMREAD (LDR) or MEMWRITE (STR).
  - MEMREAD → MEMWB.
  - EXECUTE* → ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH → FETCH.
- **RegSrc**: `RegSrc[0]` = (Op == 10); `RegSrc[1]` = (Op == 01).
- **Writeback to R15**: in MEMWB or ALUWB with `Instr[15:12]` = 1111, PCWrite = CondExR in addition to RegWrite.
- **Condition**: CondEx is evaluated from `Instr[31:28]` against the Flags register, using the ARM codes EQ..AL (0000..1110). Code 1111 evaluates false.
  - CondExR latches CondEx at the end of DECODE.
- **Flags write**: at the end of EXECUTER/EXECUTEI, when CondExR = 1 and (`Instr[20]` = 1 or CMP).
  - ADD, SUB and CMP write NZCV.
  - AND, ORR and MUL write NZ only; C and V are held.

## Timing
- Cycle counts: DP 4, CMP 4, STR 4, LDR 5, B 3, unsupported 2.
- Outputs are Moore; they depend only on state, Instr and CondExR. There is no combinational path from ALUFlags to any output.
- Reset values: state = FETCH, Flags = 0000, CondExR = 0.
  - While `reset` = 1, PCWrite, IRWrite, RegWrite and MemWrite are forced 0. The other outputs take their FETCH values.
- Reset asserted mid-instruction: abort immediately, with no further writes. After deassertion the first edge is a FETCH.
- Flags change only on the EXECUTE→ALUWB edge, so a following instruction's DECODE sees the updated flags.

## Configuration
- `CTRL_MUL_EN` defined: MUL is decoded as specified.
- `CTRL_MUL_EN` undefined: `opMul` is tied 0, and MUL encodings are unsupported (DECODE → FETCH, no writes).

## Test plan
- **ADD R1,R2,R3** (`E0821003`): reset, then 4 cycles. FETCH asserts IRWrite = PCWrite = 1. ALUWB asserts RegWrite = 1 with ResultSrc = 0, then returns to FETCH.
- **SUBS then BEQ**: SUBS with ALUFlags = 0100 sets Z. The following `0A000002` reaches BRANCH with PCWrite = 1. Repeat with ALUFlags = 0000: PCWrite = 0 in BRANCH.
- **LDR R0,[R1,#4]** (`E5910004`): FETCH, DECODE, MEMADR, MEMREAD (AdrSrc = 1), MEMWB (ResultSrc = 1, RegWrite = 1). Total 5 cycles.
- **STR with cond NE and Z = 1**: RegSrc = 10 in DECODE. MEMWRITE keeps MemWrite = 0. Total 4 cycles.
- **MUL** (`E0000291`) with `CTRL_MUL_EN`: opMul = 1, ALUControl = 100 in EXECUTER. Without the macro: 2 cycles, no enables.
- **Reset mid-MEMREAD**: all write enables drop to 0 at once. After release the state is FETCH and Flags = 0000.
